regfile_write_scheduler: RTL and testbench

- Shares the two write ports of the 2-write/4-read LVT register file among NUM_REQ writeback requesters (ALU, load unit, MUL/DIV, special-register moves).
- Grants up to two requests per cycle using round-robin. Never issues two same-address writes in one cycle.
- Drives registered we0/we1 write ports.
- Flags read ports whose address matches a write that is staged but not yet committed.

---
 rtl/regfile_write_scheduler_pkg.sv | 8 +
 rtl/regfile_write_scheduler_rr_pick2.sv | 45 ++++
 rtl/regfile_write_scheduler.sv | 67 ++++++
 tb/tb_regfile_write_scheduler.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// regfile_write_scheduler_pkg: shared widths and defaults for the register-file write scheduler
package regfile_write_scheduler_pkg;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 32;
  localparam int RF_NUM_RD = 4;
  localparam int RF_NUM_REQ = 4;
  localparam int CONFLICT_CNT_W = 16;
endpackage

// File: rtl/regfile_write_scheduler_rr_pick2.sv
// regfile_write_scheduler_rr_pick2: two-winner round-robin picker; slot1 excludes slot0's address
// Ports: valid/addr per requester, ptr scan start; slot0/slot1 one-hot, v0/v1 slot valid,
// idx0/idx1 winner indices, conflict = a valid loser shares slot0's address.
module regfile_write_scheduler_rr_pick2 #(
  parameter int N = 4,
  parameter int AW = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [N*AW-1:0] addr,
  input  logic [PW-1:0]   ptr,
  output logic [N-1:0]    slot0,
  output logic [N-1:0]    slot1,
  output logic            v0,
  output logic            v1,
  output logic [PW-1:0]   idx0,
  output logic [PW-1:0]   idx1,
  output logic            conflict
);
  logic [PW-1:0] j;
  always_comb begin
    v0 = 1'b0;
    v1 = 1'b0;
    idx0 = '0;
    idx1 = '0;
    conflict = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (valid[j]) begin
        if (!v0) begin
          v0 = 1'b1;
          idx0 = j;
        end else if (addr[j*AW +: AW] == addr[idx0*AW +: AW]) begin
          conflict = 1'b1;
        end else if (!v1) begin
          v1 = 1'b1;
          idx1 = j;
        end
      end
    end
    slot0 = v0 ? N'(1) << idx0 : '0;
    slot1 = v1 ? N'(1) << idx1 : '0;
  end
endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: grants up to two writeback requesters per cycle onto the 2W register file
// Ports: clock/reset_n; req_valid/req_addr/req_data in, req_ready grant out; registered
// we0/write_addr_0/write_data_0 and we1/write_addr_1/write_data_1; rd_addr in, rd_pending out
// flags reads hitting a staged write; conflict_cnt saturating count of address-conflict cycles.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  parameter int NUM_RD = RF_NUM_RD
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      we0,
  output logic [ADDR_W-1:0]         write_addr_0,
  output logic [DATA_W-1:0]         write_data_0,
  output logic                      we1,
  output logic [ADDR_W-1:0]         write_addr_1,
  output logic [DATA_W-1:0]         write_data_1,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0]         rd_pending,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] rr_ptr, idx0, idx1, last;
  logic [NUM_REQ-1:0] slot0, slot1;
  logic v0, v1, conflict;
  regfile_write_scheduler_rr_pick2 #(.N(NUM_REQ), .AW(ADDR_W), .PW(PW)) u_pick (
    .valid(req_valid), .addr(req_addr), .ptr(rr_ptr),
    .slot0(slot0), .slot1(slot1), .v0(v0), .v1(v1),
    .idx0(idx0), .idx1(idx1), .conflict(conflict)
  );
  assign req_ready = reset_n ? (slot0 | slot1) : '0;
  assign last = v1 ? idx1 : idx0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we0 <= 1'b0;
      we1 <= 1'b0;
      write_addr_0 <= '0;
      write_data_0 <= '0;
      write_addr_1 <= '0;
      write_data_1 <= '0;
      rr_ptr <= '0;
      conflict_cnt <= '0;
    end else begin
      we0 <= v0;
      we1 <= v1;
      write_addr_0 <= v0 ? req_addr[idx0*ADDR_W +: ADDR_W] : write_addr_0;
      write_data_0 <= v0 ? req_data[idx0*DATA_W +: DATA_W] : write_data_0;
      write_addr_1 <= v1 ? req_addr[idx1*ADDR_W +: ADDR_W] : write_addr_1;
      write_data_1 <= v1 ? req_data[idx1*DATA_W +: DATA_W] : write_data_1;
      rr_ptr <= !v0 ? rr_ptr : (last == PW'(NUM_REQ - 1)) ? '0 : last + 1'b1;
      conflict_cnt <= (conflict && conflict_cnt != '1) ? conflict_cnt + 1'b1 : conflict_cnt;
    end
  end
  always_comb begin
    rd_pending = '0;
    for (int i = 0; i < NUM_RD; i++)
      rd_pending[i] = (we0 && write_addr_0 == rd_addr[i*ADDR_W +: ADDR_W]) ||
                      (we1 && write_addr_1 == rd_addr[i*ADDR_W +: ADDR_W]);
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: randomized bench against a queue-based reference of the scheduler
module tb_regfile_write_scheduler;
  localparam int NR = 4, AW = 4, DW = 32, ND = 4;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic we0, we1;
  logic [AW-1:0] write_addr_0, write_addr_1;
  logic [DW-1:0] write_data_0, write_data_1;
  logic [ND*AW-1:0] rd_addr = '0;
  logic [ND-1:0] rd_pending;
  logic [15:0] conflict_cnt;
  regfile_write_scheduler dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .we0(we0), .write_addr_0(write_addr_0),
    .write_data_0(write_data_0), .we1(we1), .write_addr_1(write_addr_1),
    .write_data_1(write_data_1), .rd_addr(rd_addr), .rd_pending(rd_pending),
    .conflict_cnt(conflict_cnt)
  );
  always #5 clock = ~clock;
  int n_vec = 0, n_err = 0;
  bit rv[NR];
  logic [AW-1:0] ra[NR];
  logic [DW-1:0] rdat[NR];
  logic [AW-1:0] rda[ND];
  int m_ptr;
  logic m_we0, m_we1;
  logic [AW-1:0] m_wa0, m_wa1;
  logic [DW-1:0] m_wd0, m_wd1;
  int m_cnt;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_ptr = 0; m_cnt = 0;
    m_we0 = 0; m_we1 = 0; m_wa0 = '0; m_wa1 = '0; m_wd0 = '0; m_wd1 = '0;
  endtask
  task automatic new_req(input int i, input int mode);
    rv[i] = (mode == 0) ? 1'b0 : (mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
    ra[i] = (mode == 2) ? 4'd7 : AW'($urandom_range(0, 3));
    rdat[i] = $urandom;
  endtask
  // mode 0: directed (granted requesters drop), 1: random refill, 2: all same address
  task automatic step(input bit chk, input int mode);
    int q[$], c[$];
    int s0, s1;
    bit conf;
    logic [NR-1:0] e_rdy;
    logic [ND-1:0] e_pend;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = rv[i];
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*DW +: DW] = rdat[i];
    end
    for (int r = 0; r < ND; r++) rd_addr[r*AW +: AW] = rda[r];
    #1;
    for (int k = 0; k < NR; k++) if (rv[(m_ptr + k) % NR]) q.push_back((m_ptr + k) % NR);
    s0 = q.size() > 0 ? q[0] : -1;
    for (int n = 1; n < q.size(); n++) if (ra[q[n]] != ra[s0]) c.push_back(q[n]);
    s1 = c.size() > 0 ? c[0] : -1;
    conf = q.size() > 1 && c.size() != q.size() - 1;
    e_rdy = '0;
    if (s0 >= 0) e_rdy[s0] = 1'b1;
    if (s1 >= 0) e_rdy[s1] = 1'b1;
    for (int r = 0; r < ND; r++) e_pend[r] = (m_we0 && m_wa0 == rda[r]) || (m_we1 && m_wa1 == rda[r]);
    if (chk) begin
      check("ready", 32'(req_ready), 32'(e_rdy));
      check("we0", 32'(we0), 32'(m_we0));
      check("we1", 32'(we1), 32'(m_we1));
      check("wa0", 32'(write_addr_0), 32'(m_wa0));
      check("wd0", write_data_0, m_wd0);
      check("wa1", 32'(write_addr_1), 32'(m_wa1));
      check("wd1", write_data_1, m_wd1);
      check("pending", 32'(rd_pending), 32'(e_pend));
      check("cnt", 32'(conflict_cnt), 32'(m_cnt));
      check("same_addr", 32'(we0 && we1 && write_addr_0 == write_addr_1), 32'(0));
    end
    @(posedge clock);
    m_we0 = s0 >= 0;
    m_we1 = s1 >= 0;
    if (s0 >= 0) begin m_wa0 = ra[s0]; m_wd0 = rdat[s0]; end
    if (s1 >= 0) begin m_wa1 = ra[s1]; m_wd1 = rdat[s1]; end
    if (s0 >= 0) m_ptr = ((s1 >= 0 ? s1 : s0) + 1) % NR;
    if (conf && m_cnt < 16'hFFFF) m_cnt++;
    for (int i = 0; i < NR; i++) if (e_rdy[i] || (mode == 1 && !rv[i])) new_req(i, mode);
    for (int r = 0; r < ND; r++) rda[r] = AW'($urandom_range(0, 4));
    @(negedge clock);
  endtask
  initial begin
    model_reset();
    for (int i = 0; i < NR; i++) begin rv[i] = 0; ra[i] = '0; rdat[i] = '0; end
    for (int r = 0; r < ND; r++) rda[r] = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    step(1, 0);
    rv[0] = 1; ra[0] = 4'd5; rdat[0] = 32'hAAAA0000;
    rv[2] = 1; ra[2] = 4'd3; rdat[2] = 32'hBBBB2222;
    step(1, 0);
    rda[0] = 4'd5; rda[1] = 4'd3; rda[2] = 4'd4; rda[3] = 4'd9;
    step(1, 0);
    for (int i = 0; i < NR; i++) begin rv[i] = 1; ra[i] = AW'(i + 8); rdat[i] = $urandom; end
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = 1'b1;
      req_addr[i*AW +: AW] = ra[i];
    end
    step(1, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_we0", 32'(we0), 32'(0));
    check("rst_we1", 32'(we1), 32'(0));
    check("rst_cnt", 32'(conflict_cnt), 32'(0));
    check("rst_wa0", 32'(write_addr_0), 32'(0));
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < NR; i++) rv[i] = 0;
    rv[0] = 1; ra[0] = 4'd7; rdat[0] = 32'h0000_0007;
    rv[1] = 1; ra[1] = 4'd7; rdat[1] = 32'h1111_0007;
    rv[2] = 1; ra[2] = 4'd9; rdat[2] = 32'h2222_0009;
    rda[2] = 4'd7;
    step(1, 0);
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < NR; i++) begin rv[i] = 1; ra[i] = AW'(i); rdat[i] = $urandom; end
    repeat (6) step(1, 0);
    for (int i = 0; i < NR; i++) new_req(i, 1);
    repeat (400) step(1, 1);
    for (int i = 0; i < NR; i++) new_req(i, 2);
    repeat (65540) step(0, 2);
    step(1, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
